// File: rtl/mem_write_checker_pkg.sv
// Shared types for the data-memory write checker: FSM states and the expected-write table entry.
package checker_pkg;

    // Entry fields are sized for the widest supported bus (64 bits); narrower buses are zero-extended.
    localparam int CHK_W = 64;

    typedef logic [CHK_W-1:0] chk_word_t;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        PASS,
        FAIL,
        TIMEOUT
    } chk_state_t;

    typedef struct packed {
        chk_word_t addr;
        chk_word_t data;
    } chk_entry_t;

endpackage

// File: rtl/mem_write_checker_if.sv
// Data-memory write bus as seen by the checker: the CPU side drives it, the checker only observes.
interface mem_write_checker_if #(
    parameter int N = 32
);
    logic         memwrite;
    logic [N-1:0] dataadr;
    logic [N-1:0] writedata;

    modport master (output memwrite, output dataadr, output writedata);
    modport slave  (input  memwrite, input  dataadr, input  writedata);
endinterface

// File: rtl/mem_write_checker_watchdog.sv
// Saturating up-counter for the checker's cycle budget; expired flags the edge that uses up the budget.
module watchdog_counter #(
    parameter int LIMIT = 4096,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         expired
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != W'(LIMIT))) begin
            count <= count + W'(1);
        end
    end

    // High while enabled on the edge where count reaches (or already sits at) LIMIT.
    assign expired = en && (count >= W'(LIMIT - 1));

endmodule

// File: rtl/mem_write_checker.sv
// Self-checking monitor for the data-memory write bus: compares observed writes against a
// programmable table of expected (address, data) pairs and reports pass/fail/timeout.
//
// state   | meaning
// IDLE    | not armed; table may be loaded
// RUN     | armed; watching writes and counting cycles
// PASS    | every table entry was matched
// FAIL    | a write hit an expected address with the wrong data
// TIMEOUT | cycle budget used up before all entries matched
module mem_write_checker
    import checker_pkg::*;
#(
    parameter int N              = 32,
    parameter int NUM_CHECKS     = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int ORDERED        = 1,
    localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    localparam int MC_W  = $clog2(NUM_CHECKS + 1),
    localparam int CC_W  = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_en,
    input  logic [IDX_W-1:0]  load_idx,
    input  logic [N-1:0]      load_addr,
    input  logic [N-1:0]      load_data,
    mem_write_checker_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [MC_W-1:0]   match_count,
    output logic [CC_W-1:0]   cycle_count,
    output logic [N-1:0]      fail_addr,
    output logic [N-1:0]      fail_data
);

    chk_state_t state, state_nx;
    chk_entry_t tbl [NUM_CHECKS];

    logic [NUM_CHECKS-1:0] hits, hits_nx, new_hit, a_eq, d_eq;
    logic [MC_W-1:0]       count_nx;
    logic                  sample, corrupt, arm, wd_expired;

    assign sample = (state == RUN) && bus.memwrite;
    assign arm    = start && (state != RUN);

    always_comb begin
        for (int i = 0; i < NUM_CHECKS; i++) begin
            a_eq[i] = (tbl[i].addr == chk_word_t'(bus.dataadr));
            d_eq[i] = (tbl[i].data == chk_word_t'(bus.writedata));
        end
    end

    always_comb begin
        new_hit = '0;
        corrupt = 1'b0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (ORDERED != 0) begin
                // Only the entry at the current pointer (= match_count) is eligible.
                if (sample && (MC_W'(i) == match_count) && a_eq[i]) begin
                    if (d_eq[i]) new_hit[i] = 1'b1;
                    else         corrupt    = 1'b1;
                end
            end else if (sample && a_eq[i]) begin
                if (!hits[i] && d_eq[i])      new_hit[i] = 1'b1;
                else if (hits[i] && !d_eq[i]) corrupt    = 1'b1;
            end
        end
        hits_nx  = hits | new_hit;
        count_nx = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            count_nx = count_nx + MC_W'(hits_nx[i]);
        end
    end

    watchdog_counter #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (CC_W)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (arm),
        .en      (state == RUN),
        .count   (cycle_count),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            RUN: begin
                if (corrupt)                               state_nx = FAIL;
                else if (count_nx == MC_W'(NUM_CHECKS))    state_nx = PASS;
                else if (wd_expired)                       state_nx = TIMEOUT;
            end
            default: if (start) state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            hits        <= '0;
            match_count <= '0;
            fail_addr   <= '0;
            fail_data   <= '0;
        end else begin
            busy    <= (state_nx == RUN);
            done    <= (state_nx == PASS) || (state_nx == FAIL) || (state_nx == TIMEOUT);
            pass    <= (state_nx == PASS);
            fail    <= (state_nx == FAIL);
            timeout <= (state_nx == TIMEOUT);
            if (arm) begin
                hits        <= '0;
                match_count <= '0;
                fail_addr   <= '0;
                fail_data   <= '0;
            end else if (state == RUN) begin
                hits        <= hits_nx;
                match_count <= count_nx;
                if (corrupt) begin
                    fail_addr <= bus.dataadr;
                    fail_data <= bus.writedata;
                end
            end
        end
    end

    // The table is frozen while armed so a run always checks against what it started with.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHECKS; i++) tbl[i] <= '0;
        end else if (load_en && (state != RUN)) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                if (load_idx == IDX_W'(i)) begin
                    tbl[i].addr <= chk_word_t'(load_addr);
                    tbl[i].data <= chk_word_t'(load_data);
                end
            end
        end
    end

endmodule
